// File: rtl/ip_pkg.sv
// Shared IPv4 receive/transmit constants and the receive FSM state type.
package ip_pkg;

    localparam logic [15:0] C_ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  C_IP_PROTO_ICMP = 8'd1;
    localparam logic [7:0]  C_IP_PROTO_UDP  = 8'd17;
    localparam logic [3:0]  C_IP_MIN_HDR    = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DROP
    } ip_state_e;

endpackage

// File: rtl/ip_hdr_checksum.sv
// Byte-serial ones-complement header sum; ok reflects the word completed
// by the current byte so a caller can decide on the final header byte.
module ip_hdr_checksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       byte_index,
    input  logic [7:0] data,
    output logic       ok
);

    logic [7:0]  hi_q;
    logic [15:0] acc_q;
    logic [15:0] base;
    logic [16:0] sum;
    logic [15:0] folded;

    always_comb begin
        base   = clear ? 16'd0 : acc_q;
        sum    = {1'b0, base} + {1'b0, hi_q, data};
        folded = sum[15:0] + {15'd0, sum[16]};
        ok     = (en && byte_index) ? (folded == 16'hFFFF)
                                    : (acc_q == 16'hFFFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= 8'd0;
            acc_q <= 16'd0;
        end else begin
            if (en && !byte_index)
                hi_q <= data;
            if (en && byte_index)
                acc_q <= folded;
            else if (clear)
                acc_q <= 16'd0;
        end
    end

endmodule

// File: rtl/ip_rx.sv
// IPv4 receive layer: header parse/validate, padding strip and
// UDP/ICMP payload demultiplexing.
module ip_rx
    import ip_pkg::*;
#(
    parameter logic [31:0] P_SRC_IP       = {8'd192, 8'd168, 8'd01, 8'd0},
    parameter bit          P_BROADCAST_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_src_ip,
    input  logic        i_src_ip_valid,
    input  logic [15:0] i_mac_type,
    input  logic [7:0]  i_mac_data,
    input  logic        i_mac_last,
    input  logic        i_mac_valid,
    output logic [7:0]  o_udp_data,
    output logic [15:0] o_udp_len,
    output logic        o_udp_last,
    output logic        o_udp_valid,
    output logic [7:0]  o_icmp_data,
    output logic [15:0] o_icmp_len,
    output logic        o_icmp_last,
    output logic        o_icmp_valid,
    output logic [31:0] o_recv_src_ip,
    output logic        o_recv_src_valid,
    output logic        o_hdr_error,
    output logic        o_trunc_error
);

    ip_state_e   state_q, state_d;
    logic [31:0] ip_shd_q, ip_act_q;
    logic [5:0]  cnt_q;
    logic [3:0]  ver_q, ihl_q;
    logic [15:0] tlen_q;
    logic [13:0] frag_q;
    logic [7:0]  proto_q;
    logic [31:0] src_q, dst_q;
    logic [15:0] rem_q;
    logic        udp_sel_q;

    logic        is_ipv4, csum_en, csum_idx, csum_clr, csum_ok;
    logic [5:0]  last_idx;
    logic [15:0] hlen, plen;
    logic [31:0] dst_w;
    logic        proto_udp, hdr_end, hdr_bad, pass;
    logic        accept, hdr_err_d, trunc_d, fwd, fwd_last;

    ip_hdr_checksum u_csum (
        .clk        (i_clk),
        .rst        (i_rst),
        .clear      (csum_clr),
        .en         (csum_en),
        .byte_index (csum_idx),
        .data       (i_mac_data),
        .ok         (csum_ok)
    );

    always_comb begin
        is_ipv4  = (i_mac_type == C_ETH_TYPE_IPV4);
        csum_clr = (state_q == S_IDLE);
        csum_en  = i_mac_valid &&
                   ((state_q == S_IDLE && is_ipv4) || state_q == S_HEADER);
        csum_idx = (state_q == S_HEADER) ? cnt_q[0] : 1'b0;
        hlen     = {10'd0, ihl_q, 2'b00};
        plen     = tlen_q - hlen;
        // A short IHL still runs to the minimum header so it is reported.
        last_idx = (ihl_q < C_IP_MIN_HDR) ? 6'd19
                                          : {ihl_q, 2'b00} - 6'd1;
        hdr_end  = (state_q == S_HEADER) && i_mac_valid &&
                   (cnt_q == last_idx);
        dst_w    = (cnt_q == 6'd19) ? {dst_q[23:0], i_mac_data} : dst_q;
        proto_udp = (proto_q == C_IP_PROTO_UDP);
        hdr_bad  = (ver_q != 4'd4) || (ihl_q < C_IP_MIN_HDR) ||
                   (hlen >= tlen_q) || !csum_ok;
        pass     = (frag_q == 14'd0) &&
                   (dst_w == ip_act_q ||
                    (P_BROADCAST_EN && dst_w == 32'hFFFF_FFFF)) &&
                   (proto_udp || proto_q == C_IP_PROTO_ICMP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (i_mac_valid && !i_mac_last)
                    state_d = is_ipv4 ? S_HEADER : S_DROP;
            S_HEADER:
                if (i_mac_valid && i_mac_last)
                    state_d = S_IDLE;
                else if (hdr_end)
                    state_d = (!hdr_bad && pass) ? S_PAYLOAD : S_DROP;
            S_PAYLOAD:
                if (i_mac_valid && i_mac_last)
                    state_d = S_IDLE;
                else if (i_mac_valid && rem_q == 16'd1)
                    state_d = S_DROP;
            S_DROP:
                if (i_mac_valid && i_mac_last)
                    state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = hdr_end && !i_mac_last && !hdr_bad && pass;
        hdr_err_d = hdr_end && !i_mac_last && hdr_bad;
        fwd       = (state_q == S_PAYLOAD) && i_mac_valid;
        fwd_last  = fwd && (rem_q == 16'd1 || i_mac_last);
        trunc_d   = i_mac_valid && i_mac_last &&
                    ((state_q == S_HEADER) ||
                     (state_q == S_IDLE && is_ipv4) ||
                     (state_q == S_PAYLOAD && rem_q != 16'd1));
    end

    // New local IP only becomes active between frames.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ip_shd_q <= P_SRC_IP;
            ip_act_q <= P_SRC_IP;
        end else begin
            if (i_src_ip_valid)
                ip_shd_q <= i_src_ip;
            if (state_q == S_IDLE)
                ip_act_q <= ip_shd_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q     <= 6'd0;
            ver_q     <= 4'd0;
            ihl_q     <= 4'd0;
            tlen_q    <= 16'd0;
            frag_q    <= 14'd0;
            proto_q   <= 8'd0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            rem_q     <= 16'd0;
            udp_sel_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_mac_valid) begin
                {ver_q, ihl_q} <= i_mac_data;
                cnt_q          <= 6'd1;
            end else if (state_q == S_HEADER && i_mac_valid) begin
                cnt_q <= cnt_q + 6'd1;
                unique case (1'b1)
                    cnt_q == 6'd2: tlen_q[15:8] <= i_mac_data;
                    cnt_q == 6'd3: tlen_q[7:0]  <= i_mac_data;
                    cnt_q == 6'd6: frag_q[13:8] <= i_mac_data[5:0];
                    cnt_q == 6'd7: frag_q[7:0]  <= i_mac_data;
                    cnt_q == 6'd9: proto_q      <= i_mac_data;
                    cnt_q >= 6'd12 && cnt_q <= 6'd15:
                        src_q <= {src_q[23:0], i_mac_data};
                    cnt_q >= 6'd16 && cnt_q <= 6'd19:
                        dst_q <= {dst_q[23:0], i_mac_data};
                    default: ;
                endcase
            end
            if (accept) begin
                rem_q     <= plen;
                udp_sel_q <= proto_udp;
            end else if (fwd) begin
                rem_q <= rem_q - 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_udp_data       <= 8'd0;
            o_udp_len        <= 16'd0;
            o_udp_last       <= 1'b0;
            o_udp_valid      <= 1'b0;
            o_icmp_data      <= 8'd0;
            o_icmp_len       <= 16'd0;
            o_icmp_last      <= 1'b0;
            o_icmp_valid     <= 1'b0;
            o_recv_src_ip    <= 32'd0;
            o_recv_src_valid <= 1'b0;
            o_hdr_error      <= 1'b0;
            o_trunc_error    <= 1'b0;
        end else begin
            o_udp_valid      <= fwd && udp_sel_q;
            o_udp_last       <= fwd_last && udp_sel_q;
            o_udp_data       <= (fwd && udp_sel_q) ? i_mac_data : 8'd0;
            o_icmp_valid     <= fwd && !udp_sel_q;
            o_icmp_last      <= fwd_last && !udp_sel_q;
            o_icmp_data      <= (fwd && !udp_sel_q) ? i_mac_data : 8'd0;
            o_recv_src_valid <= accept;
            o_hdr_error      <= hdr_err_d;
            o_trunc_error    <= trunc_d;
            if (accept) begin
                o_recv_src_ip <= src_q;
                o_udp_len     <= proto_udp ? plen : 16'd0;
                o_icmp_len    <= proto_udp ? 16'd0 : plen;
            end
        end
    end

endmodule

// File: tb/tb_ip_rx.sv
// Self-checking bench for ip_rx: directed frames plus random frames
// checked against a frame-level reference model.
module tb_ip_rx;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_src_ip;
    logic        i_src_ip_valid;
    logic [15:0] i_mac_type;
    logic [7:0]  i_mac_data;
    logic        i_mac_last;
    logic        i_mac_valid;
    logic [7:0]  o_udp_data, o_icmp_data;
    logic [15:0] o_udp_len, o_icmp_len;
    logic        o_udp_last, o_udp_valid, o_icmp_last, o_icmp_valid;
    logic [31:0] o_recv_src_ip;
    logic        o_recv_src_valid, o_hdr_error, o_trunc_error;

    ip_rx dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_src_ip         (i_src_ip),
        .i_src_ip_valid   (i_src_ip_valid),
        .i_mac_type       (i_mac_type),
        .i_mac_data       (i_mac_data),
        .i_mac_last       (i_mac_last),
        .i_mac_valid      (i_mac_valid),
        .o_udp_data       (o_udp_data),
        .o_udp_len        (o_udp_len),
        .o_udp_last       (o_udp_last),
        .o_udp_valid      (o_udp_valid),
        .o_icmp_data      (o_icmp_data),
        .o_icmp_len       (o_icmp_len),
        .o_icmp_last      (o_icmp_last),
        .o_icmp_valid     (o_icmp_valid),
        .o_recv_src_ip    (o_recv_src_ip),
        .o_recv_src_valid (o_recv_src_valid),
        .o_hdr_error      (o_hdr_error),
        .o_trunc_error    (o_trunc_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] loc_ip;

    // Observed activity
    bq_t         got_udp, got_icmp;
    int          got_ulast[$], got_ilast[$];
    logic [31:0] got_src[$];
    logic [15:0] got_ulen[$], got_ilen[$];
    int          n_herr, n_trunc, n_both;

    // Expected activity
    bq_t         exp_udp, exp_icmp;
    int          exp_ulast[$], exp_ilast[$];
    logic [31:0] exp_src[$];
    logic [15:0] exp_len[$];
    bit          exp_sel[$];
    int          exp_herr, exp_trunc;

    always @(posedge clk) begin
        #1;
        if (o_udp_valid) begin
            got_udp.push_back(o_udp_data);
            if (o_udp_last) got_ulast.push_back(got_udp.size() - 1);
        end
        if (o_icmp_valid) begin
            got_icmp.push_back(o_icmp_data);
            if (o_icmp_last) got_ilast.push_back(got_icmp.size() - 1);
        end
        if (o_udp_valid && o_icmp_valid) n_both++;
        if (o_hdr_error) n_herr++;
        if (o_trunc_error) n_trunc++;
        if (o_recv_src_valid) begin
            got_src.push_back(o_recv_src_ip);
            got_ulen.push_back(o_udp_len);
            got_ilen.push_back(o_icmp_len);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build(output bq_t f, input logic [7:0] proto,
                                  input logic [31:0] src,
                                  input logic [31:0] dst, input int ihl,
                                  input int tl, input bq_t pay,
                                  input logic [15:0] ff);
        int s;
        logic [15:0] c;
        f = {};
        f.push_back({4'd4, 4'(ihl)});
        f.push_back(8'h00);
        f.push_back(8'(tl >> 8));
        f.push_back(8'(tl));
        f.push_back(8'h12);
        f.push_back(8'h34);
        f.push_back(ff[15:8]);
        f.push_back(ff[7:0]);
        f.push_back(8'd64);
        f.push_back(proto);
        f.push_back(8'h00);
        f.push_back(8'h00);
        for (int i = 0; i < 4; i++) f.push_back(src[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) f.push_back(dst[31-8*i -: 8]);
        while (f.size() < ihl * 4) f.push_back(8'($urandom));
        s = 0;
        for (int i = 0; i < ihl * 4; i += 2) s += {16'd0, f[i], f[i+1]};
        while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
        c = ~16'(s);
        f[10] = c[15:8];
        f[11] = c[7:0];
        foreach (pay[i]) f.push_back(pay[i]);
    endfunction

    // Reference: what a complete frame should produce, from header rules.
    task automatic model(input bq_t f, input logic [15:0] et);
        int n, ihl, hl, tl, s, len, k;
        logic [7:0] b0;
        logic [15:0] ffw;
        logic [31:0] dst, src;
        logic [7:0] proto;
        n = f.size();
        if (et != 16'h0800) return;
        b0  = f[0];
        ihl = int'(b0[3:0]);
        hl  = (ihl < 5) ? 20 : ihl * 4;
        if (n <= hl) begin
            exp_trunc++;
            return;
        end
        s = 0;
        for (int i = 0; i < hl; i += 2) s += {16'd0, f[i], f[i+1]};
        while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
        tl = {f[2], f[3]};
        if (b0[7:4] != 4'd4 || ihl < 5 || hl >= tl || s != 'hFFFF) begin
            exp_herr++;
            return;
        end
        ffw   = {f[6], f[7]};
        src   = {f[12], f[13], f[14], f[15]};
        dst   = {f[16], f[17], f[18], f[19]};
        proto = f[9];
        if (ffw[13:0] != 0) return;
        if (dst != loc_ip && dst != 32'hFFFF_FFFF) return;
        if (proto != 8'd1 && proto != 8'd17) return;
        len = tl - hl;
        k   = (n - hl < len) ? n - hl : len;
        exp_src.push_back(src);
        exp_len.push_back(16'(len));
        exp_sel.push_back(proto == 8'd17);
        for (int i = 0; i < k; i++) begin
            if (proto == 8'd17) exp_udp.push_back(f[hl+i]);
            else exp_icmp.push_back(f[hl+i]);
        end
        if (proto == 8'd17) exp_ulast.push_back(exp_udp.size() - 1);
        else exp_ilast.push_back(exp_icmp.size() - 1);
        if (k < len) exp_trunc++;
    endtask

    task automatic send(input bq_t f, input logic [15:0] et,
                        input bit with_last);
        for (int i = 0; i < f.size(); i++) begin
            @(negedge clk);
            i_mac_valid = 1'b1;
            i_mac_type  = et;
            i_mac_data  = f[i];
            i_mac_last  = with_last && (i == f.size() - 1);
        end
    endtask

    task automatic tx(input bq_t f, input logic [15:0] et);
        model(f, et);
        send(f, et, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_mac_valid = 1'b0;
            i_mac_last  = 1'b0;
            i_mac_data  = 8'd0;
        end
    endtask

    task automatic checkpoint(input string tag);
        int m;
        idle(4);
        check({tag, "_udp_n"}, got_udp.size(), exp_udp.size());
        m = (got_udp.size() < exp_udp.size()) ? got_udp.size() : exp_udp.size();
        for (int i = 0; i < m; i++)
            check({tag, "_udp_byte"}, got_udp[i], exp_udp[i]);
        check({tag, "_icmp_n"}, got_icmp.size(), exp_icmp.size());
        m = (got_icmp.size() < exp_icmp.size()) ? got_icmp.size() : exp_icmp.size();
        for (int i = 0; i < m; i++)
            check({tag, "_icmp_byte"}, got_icmp[i], exp_icmp[i]);
        check({tag, "_ulast_n"}, got_ulast.size(), exp_ulast.size());
        foreach (got_ulast[i])
            if (i < exp_ulast.size())
                check({tag, "_ulast_pos"}, got_ulast[i], exp_ulast[i]);
        check({tag, "_ilast_n"}, got_ilast.size(), exp_ilast.size());
        foreach (got_ilast[i])
            if (i < exp_ilast.size())
                check({tag, "_ilast_pos"}, got_ilast[i], exp_ilast[i]);
        check({tag, "_accept_n"}, got_src.size(), exp_src.size());
        foreach (got_src[i])
            if (i < exp_src.size()) begin
                check({tag, "_src_ip"}, got_src[i], exp_src[i]);
                check({tag, "_len"}, exp_sel[i] ? got_ulen[i] : got_ilen[i],
                      exp_len[i]);
            end
        check({tag, "_hdr_err"}, n_herr, exp_herr);
        check({tag, "_trunc_err"}, n_trunc, exp_trunc);
        check({tag, "_both_valid"}, n_both, 0);
        got_udp = {}; got_icmp = {}; got_ulast = {}; got_ilast = {};
        got_src = {}; got_ulen = {}; got_ilen = {};
        exp_udp = {}; exp_icmp = {}; exp_ulast = {}; exp_ilast = {};
        exp_src = {}; exp_len = {}; exp_sel = {};
        n_herr = 0; n_trunc = 0; n_both = 0; exp_herr = 0; exp_trunc = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strobes"}, {25'd0, o_udp_valid, o_udp_last, o_icmp_valid,
              o_icmp_last, o_recv_src_valid, o_hdr_error, o_trunc_error}, 0);
        check({tag, "_data_len"}, {o_udp_data, o_icmp_data, o_udp_len}, 0);
        check({tag, "_icmp_len"}, {16'd0, o_icmp_len}, 0);
        check({tag, "_src_ip"}, o_recv_src_ip, 0);
    endtask

    localparam logic [31:0] PEER = {8'd192, 8'd168, 8'd1, 8'd1};

    initial begin
        bq_t f, g, pay, p8;
        logic [31:0] dst;
        logic [7:0]  proto;
        logic [15:0] et, ff;
        int ihl, plen, cut, pos;

        rst = 1'b1;
        i_src_ip = 32'd0;
        i_src_ip_valid = 1'b0;
        i_mac_type = 16'd0;
        i_mac_data = 8'd0;
        i_mac_last = 1'b0;
        i_mac_valid = 1'b0;
        loc_ip = {8'd192, 8'd168, 8'd1, 8'd0};
        n_herr = 0; n_trunc = 0; n_both = 0; exp_herr = 0; exp_trunc = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        pay = {};
        for (int i = 0; i < 100; i++) pay.push_back(8'(i));
        build(f, 8'd17, PEER, loc_ip, 5, 120, pay, 16'h0000);
        tx(f, 16'h0800);
        checkpoint("udp100");

        p8 = {};
        for (int i = 0; i < 8; i++) p8.push_back(8'(8'hA0 + i));
        build(g, 8'd1, PEER, loc_ip, 5, 28, p8, 16'h0000);
        for (int i = 0; i < 18; i++) g.push_back(8'h00);
        tx(g, 16'h0800);
        tx(f, 16'h0800);
        checkpoint("icmp_pad_b2b");

        g = f;
        g[8] = g[8] ^ 8'h01;
        tx(g, 16'h0800);
        checkpoint("corrupt");

        build(g, 8'd17, PEER, {8'd192, 8'd168, 8'd1, 8'd5}, 5, 120, pay, 16'h0);
        tx(g, 16'h0800);
        tx(f, 16'h0806);
        build(g, 8'd17, PEER, 32'hFFFF_FFFF, 5, 120, pay, 16'h0);
        tx(g, 16'h0800);
        checkpoint("addr_type_bcast");

        g = {};
        for (int i = 0; i < 50; i++) g.push_back(pay[i]);
        build(g, 8'd17, PEER, loc_ip, 5, 120, g, 16'h0);
        tx(g, 16'h0800);
        checkpoint("trunc");

        g = {};
        for (int i = 0; i < 30; i++) g.push_back(8'($urandom));
        build(f, 8'd17, PEER, loc_ip, 6, 54, g, 16'h0);
        f = f[0:33];
        send(f, 16'h0800, 1'b0);
        exp_src.push_back(PEER);
        exp_len.push_back(16'd30);
        exp_sel.push_back(1'b1);
        for (int i = 0; i < 10; i++) exp_udp.push_back(g[i]);
        @(negedge clk);
        i_mac_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        checkpoint("ihl6_reset");
        build(f, 8'd17, PEER, loc_ip, 5, 120, pay, 16'h0000);
        tx(f, 16'h0800);
        checkpoint("after_reset");

        @(negedge clk);
        i_src_ip = {8'd10, 8'd0, 8'd0, 8'd7};
        i_src_ip_valid = 1'b1;
        @(negedge clk);
        i_src_ip_valid = 1'b0;
        idle(3);
        loc_ip = {8'd10, 8'd0, 8'd0, 8'd7};

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: dst = loc_ip;
                1: dst = 32'hFFFF_FFFF;
                2: dst = $urandom;
                default: dst = {8'd192, 8'd168, 8'd1, 8'd0};
            endcase
            case ($urandom_range(0, 3))
                0: proto = 8'd1;
                1: proto = 8'd6;
                default: proto = 8'd17;
            endcase
            ihl  = $urandom_range(5, 7);
            plen = $urandom_range(1, 40);
            ff   = ($urandom_range(0, 7) == 0) ? 16'h2000 : 16'h4000;
            et   = ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800;
            g = {};
            for (int i = 0; i < plen; i++) g.push_back(8'($urandom));
            build(f, proto, $urandom, dst, ihl, ihl * 4 + plen, g, ff);
            for (int i = $urandom_range(0, 8); i > 0; i--)
                f.push_back(8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                pos = $urandom_range(0, ihl * 4 - 1);
                f[pos] = f[pos] ^ (8'd1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 7) == 0) begin
                cut = $urandom_range(1, f.size());
                while (f.size() > cut) void'(f.pop_back());
            end
            tx(f, et);
            if ($urandom_range(0, 2) != 0) checkpoint("random");
        end
        checkpoint("random_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
